// File: rtl/lcd_hd44780_driver.sv
// HD44780 character LCD write-only driver: autonomous power-up init, timed
// setup / enable / execution phases, and a 4-phase req/ack handshake upstream.
module lcd_hd44780_driver #(
  parameter int T_POWERUP   = 1000000,
  parameter int T_SETUP     = 3,
  parameter int T_EN_HIGH   = 25,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ctrl_data,
  input  logic       ctrl_data_is_cmd,
  input  logic       ctrl_data_req,
  output logic       ctrl_data_ack,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       ready
);

  typedef enum logic [3:0] {
    S_POWERUP,
    S_I_SETUP,
    S_I_PULSE,
    S_I_WAIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [23:0] C_POWERUP   = 24'(T_POWERUP - 1);
  localparam logic [23:0] C_SETUP     = 24'(T_SETUP - 1);
  localparam logic [23:0] C_EN_HIGH   = 24'(T_EN_HIGH - 1);
  localparam logic [23:0] C_EXEC      = 24'(T_EXEC - 1);
  localparam logic [23:0] C_EXEC_LONG = 24'(T_EXEC_LONG - 1);
  localparam logic [2:0]  INIT_LAST   = 3'd5;

  // 8-bit bus, 2 lines, display on / cursor off, clear, entry increment.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      3'd5:             init_cmd = 8'h06;
      default:          init_cmd = 8'h00;
    endcase
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_next;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_next;
  logic [7:0]  r_data;
  logic [7:0]  w_data_next;
  logic        r_rs;
  logic        w_rs_next;
  logic        r_en;
  logic        w_en_next;
  logic        r_ack;
  logic        w_ack_next;
  logic        r_ready;
  logic        w_ready_next;
  logic        r_long;
  logic        w_long_next;

  logic        w_cnt_zero;
  logic        w_req_is_long;

  assign w_cnt_zero    = (r_cnt == 24'd0);
  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign w_req_is_long = ctrl_data_is_cmd && (ctrl_data[7:2] == 6'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_POWERUP;
      r_cnt   <= C_POWERUP;
      r_idx   <= 3'd0;
      r_data  <= 8'h00;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
      r_ready <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_data  <= w_data_next;
      r_rs    <= w_rs_next;
      r_en    <= w_en_next;
      r_ack   <= w_ack_next;
      r_ready <= w_ready_next;
      r_long  <= w_long_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_data_next  = r_data;
    w_rs_next    = r_rs;
    w_en_next    = r_en;
    w_ack_next   = r_ack;
    w_ready_next = r_ready;
    w_long_next  = r_long;

    case (r_state)
      S_POWERUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_I_SETUP;
          w_cnt_next   = C_SETUP;
          w_data_next  = init_cmd(r_idx);
          w_rs_next    = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_I_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_I_PULSE;
          w_cnt_next   = C_EN_HIGH;
          w_en_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_I_PULSE: begin
        if (w_cnt_zero) begin
          w_state_next = S_I_WAIT;
          w_cnt_next   = C_EXEC_LONG;
          w_en_next    = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_I_WAIT: begin
        if (w_cnt_zero) begin
          if (r_idx == INIT_LAST) begin
            w_state_next = S_IDLE;
            w_ready_next = 1'b1;
          end else begin
            w_state_next = S_I_SETUP;
            w_idx_next   = r_idx + 3'd1;
            w_cnt_next   = C_SETUP;
            w_data_next  = init_cmd(r_idx + 3'd1);
            w_rs_next    = 1'b0;
          end
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_IDLE: begin
        if (ctrl_data_req && !r_ack) begin
          w_state_next = S_SETUP;
          w_cnt_next   = C_SETUP;
          w_data_next  = ctrl_data;
          w_rs_next    = !ctrl_data_is_cmd;
          w_long_next  = w_req_is_long;
        end
      end

      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_next = S_PULSE;
          w_cnt_next   = C_EN_HIGH;
          w_en_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_next = S_WAIT;
          w_cnt_next   = r_long ? C_EXEC_LONG : C_EXEC;
          w_en_next    = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_WAIT: begin
        if (w_cnt_zero) begin
          w_state_next = S_ACK;
          w_ack_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 24'd1;
        end
      end

      S_ACK: begin
        if (!ctrl_data_req) begin
          w_state_next = S_IDLE;
          w_ack_next   = 1'b0;
        end
      end

      default: begin
        w_state_next = S_POWERUP;
        w_cnt_next   = C_POWERUP;
        w_idx_next   = 3'd0;
        w_en_next    = 1'b0;
        w_ack_next   = 1'b0;
        w_ready_next = 1'b0;
      end
    endcase
  end

  assign ctrl_data_ack = r_ack;
  assign lcd_data      = r_data;
  assign lcd_rs        = r_rs;
  assign lcd_rw        = 1'b0;
  assign lcd_en        = r_en;
  assign ready         = r_ready;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Bench for lcd_hd44780_driver: scoreboard of expected enable pulses plus a
// table of single transfers and hand-written reset / pending-request sequences.
module tb_lcd_hd44780_driver;

  localparam int TP = 10;
  localparam int TS = 2;
  localparam int TE = 3;
  localparam int TX = 5;
  localparam int TL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ctrl_data = 8'h00;
  logic       ctrl_data_is_cmd = 1'b0;
  logic       ctrl_data_req = 1'b0;
  logic       ctrl_data_ack;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       ready;

  lcd_hd44780_driver #(
    .T_POWERUP  (TP),
    .T_SETUP    (TS),
    .T_EN_HIGH  (TE),
    .T_EXEC     (TX),
    .T_EXEC_LONG(TL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_data       (ctrl_data),
    .ctrl_data_is_cmd(ctrl_data_is_cmd),
    .ctrl_data_req   (ctrl_data_req),
    .ctrl_data_ack   (ctrl_data_ack),
    .lcd_data        (lcd_data),
    .lcd_rs          (lcd_rs),
    .lcd_rw          (lcd_rw),
    .lcd_en          (lcd_en),
    .ready           (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       rs;
  } pulse_t;

  typedef struct {
    logic [7:0] data;
    logic       is_cmd;
    logic       exp_rs;
    int         exp_wait;
    int         hold;
  } vec_t;

  pulse_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int         n_pulses = 0;
  int         last_fall_cyc = 0;
  int         first_rise_cyc = -1;
  int         width = 0;
  logic       prev_en = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       p_rs = 1'b0;
  logic       p_stable = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Pulse monitor: measures each enable pulse and scores it against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      prev_en        = 1'b0;
      width          = 0;
      first_rise_cyc = -1;
    end else begin
      if (lcd_en && !prev_en) begin
        width    = 1;
        p_data   = lcd_data;
        p_rs     = lcd_rs;
        p_stable = 1'b1;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
      end else if (lcd_en) begin
        width++;
        if (lcd_data !== p_data || lcd_rs !== p_rs) p_stable = 1'b0;
      end else if (prev_en) begin
        pulse_t e;
        n_pulses++;
        last_fall_cyc = cyc;
        $display("pulse %0d data=%02h rs=%0d width=%0d cycle=%0d", n_pulses, p_data, p_rs, width, cyc);
        check("en_width", width, TE);
        check("pulse_stable", p_stable, 1);
        check("lcd_rw", lcd_rw, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got data %02h, none expected", p_data);
        end else begin
          e = exp_q.pop_front();
          check("pulse_data", p_data, e.data);
          check("pulse_rs", p_rs, e.rs);
        end
      end
      prev_en = lcd_en;
    end
  end

  task automatic push_init();
    logic [7:0] seq [6];
    seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) exp_q.push_back('{seq[i], 1'b0});
  endtask

  task automatic release_reset(output int rel_cyc, output int p0);
    @(negedge clk);
    rst     = 1'b1;
    rel_cyc = cyc;
    p0      = n_pulses;
  endtask

  task automatic wait_ready(input int rel_cyc, input int p0);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      fail_now("ready_timeout");
    end else begin
      $display("init done: ready at cycle %0d, pulses=%0d", cyc, n_pulses - p0);
      check("first_rise_delay", first_rise_cyc - rel_cyc, TP + TS);
      check("ready_delay", cyc - last_fall_cyc, TL);
      check("init_pulses", n_pulses - p0, 6);
    end
  endtask

  task automatic wait_ack(output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (ctrl_data_ack !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ctrl_data_ack !== 1'b1) begin
      fail_now("ack_timeout");
      ok = 1'b0;
    end
  endtask

  task automatic finish_handshake(input int hold);
    logic held;
    held = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ctrl_data_ack !== 1'b1) held = 1'b0;
    end
    check("ack_hold", held, 1);
    ctrl_data_req = 1'b0;
    @(negedge clk);
    check("ack_clear", ctrl_data_ack, 0);
  endtask

  task automatic do_xfer(input vec_t v);
    int   p0;
    logic ok;
    p0 = n_pulses;
    exp_q.push_back('{v.data, v.exp_rs});
    @(negedge clk);
    ctrl_data        = v.data;
    ctrl_data_is_cmd = v.is_cmd;
    ctrl_data_req    = 1'b1;
    // Scramble the inputs once the request has been accepted.
    @(negedge clk);
    ctrl_data        = ~v.data;
    ctrl_data_is_cmd = ~v.is_cmd;
    wait_ack(ok);
    if (!ok) begin
      ctrl_data_req = 1'b0;
      return;
    end
    $display("xfer data=%02h is_cmd=%0d ack_delay=%0d hold=%0d", v.data, v.is_cmd,
             cyc - last_fall_cyc, v.hold);
    check("ack_delay", cyc - last_fall_cyc, v.exp_wait);
    check("held_data", lcd_data, v.data);
    check("held_rs", lcd_rs, v.exp_rs);
    finish_handshake(v.hold);
    check("one_pulse", n_pulses - p0, 1);
  endtask

  vec_t vecs[8];

  initial begin
    int   rel;
    int   p0;
    logic ok;

    vecs[0] = '{8'h41, 1'b0, 1'b1, TX, 3};
    vecs[1] = '{8'h01, 1'b1, 1'b0, TL, 2};
    vecs[2] = '{8'h80, 1'b1, 1'b0, TX, 1};
    vecs[3] = '{8'h02, 1'b1, 1'b0, TL, 1};
    vecs[4] = '{8'h03, 1'b1, 1'b0, TL, 1};
    vecs[5] = '{8'h04, 1'b1, 1'b0, TX, 1};
    vecs[6] = '{8'h00, 1'b0, 1'b1, TX, 1};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, TX, 20};

    repeat (3) @(negedge clk);
    check("rst_ack", ctrl_data_ack, 0);
    check("rst_data", lcd_data, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_en", lcd_en, 0);
    check("rst_ready", ready, 0);

    push_init();
    release_reset(rel, p0);
    wait_ready(rel, p0);

    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    // Request pending across reset release: served only after init completes.
    @(negedge clk);
    rst              = 1'b0;
    ctrl_data        = 8'h5A;
    ctrl_data_is_cmd = 1'b0;
    ctrl_data_req    = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    exp_q.push_back('{8'h5A, 1'b1});
    release_reset(rel, p0);
    check("pending_no_ack", ctrl_data_ack, 0);
    wait_ready(rel, p0);
    wait_ack(ok);
    if (ok) begin
      $display("xfer pending data=5a ack_delay=%0d", cyc - last_fall_cyc);
      check("pending_ack_delay", cyc - last_fall_cyc, TX);
      check("pending_pulses", n_pulses - p0, 7);
      finish_handshake(1);
    end else begin
      ctrl_data_req = 1'b0;
    end

    // Reset asserted in the middle of a data write's enable pulse.
    exp_q.push_back('{8'h33, 1'b1});
    @(negedge clk);
    ctrl_data        = 8'h33;
    ctrl_data_is_cmd = 1'b0;
    ctrl_data_req    = 1'b1;
    begin
      int n;
      n = 0;
      while (lcd_en !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (lcd_en !== 1'b1) fail_now("pulse_timeout");
    end
    #1;
    rst = 1'b0;
    #1;
    $display("reset mid-pulse at cycle %0d: en=%0d ack=%0d", cyc, lcd_en, ctrl_data_ack);
    check("midrst_en", lcd_en, 0);
    check("midrst_ack", ctrl_data_ack, 0);
    check("midrst_ready", ready, 0);
    ctrl_data_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_init();
    release_reset(rel, p0);
    wait_ready(rel, p0);

    do_xfer(vecs[0]);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
